// File: rtl/pc_fetch_sequencer_pkg.sv
// Purpose: shared types and defaults for the PC fetch sequencer (state codes, PC-select codes, strobe bundle).
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: PC_W, RESET_PC_DEF, TIMEOUT_DEF, WAIT_CNT_W, state_t, pc_sel_t, strobe_t, decode_strobes().
package pc_fetch_sequencer_pkg;

   localparam int              PC_W         = 16;
   localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h3000;
   localparam int              TIMEOUT_DEF  = 15;
   localparam int              WAIT_CNT_W   = 4;

   // Encodings are visible on the debug state port, so they are fixed.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_ADDR = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_LOAD_IR    = 3'd3,
      ST_EXEC       = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'd0,
      PC_INC   = 2'd1,
      PC_REDIR = 2'd2,
      PC_DEC   = 2'd3
   } pc_sel_t;

   typedef struct packed {
      logic ld_mar;
      logic mem_rd;
      logic ld_ir;
   } strobe_t;

   // Moore decode of the datapath strobes for a given state.
   function automatic strobe_t decode_strobes(input state_t s);
      strobe_t st;
      st.ld_mar = (s == ST_FETCH_ADDR);
      st.mem_rd = (s == ST_FETCH_WAIT);
      st.ld_ir  = (s == ST_LOAD_IR);
      return st;
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_mux.sv
// Purpose: next-PC selection (hold / pc+1 / redirect target / pc-1) around a 16-bit carry-select adder.
// Latency: combinational.
// Backpressure: n/a.
// Ports (pc_next_mux): pc, redir_addr, sel -> pc_nxt.  Ports (csa16): a, b, cin -> sum, cout.
import pc_fetch_sequencer_pkg::*;

module csa16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   // Four 4-bit blocks; each precomputes both carry-in cases and the
   // incoming block carry picks one.
   logic [4:0] c;
   assign c[0] = cin;

   for (genvar g = 0; g < 4; g++) begin : g_blk
      logic [4:0] s0;
      logic [4:0] s1;
      assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
      assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
      assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
      assign c[g+1]        = c[g] ? s1[4]   : s0[4];
   end

   assign cout = c[4];
endmodule

module pc_next_mux (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] redir_addr,
   input  pc_sel_t         sel,
   output logic [PC_W-1:0] pc_nxt
);
   logic [PC_W-1:0] addend;
   logic [PC_W-1:0] sum;
   logic            carry_unused;

   // pc-1 is pc + 0xFFFF; carry-out discarded so both directions wrap mod 2^16.
   assign addend = (sel == PC_DEC) ? 16'hFFFF : 16'h0001;

   csa16 u_csa16 (
      .a    (pc),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry_unused)
   );

   always_comb begin
      pc_nxt = pc;
      case (sel)
         PC_HOLD:  pc_nxt = pc;
         PC_INC:   pc_nxt = sum;
         PC_DEC:   pc_nxt = sum;
         PC_REDIR: pc_nxt = redir_addr;
         default:  pc_nxt = pc;
      endcase
   end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Purpose: steps the 16-bit PC through ADDR -> WAIT -> LOAD_IR -> EXEC per instruction.
// Latency: min 4 cycles per instruction; strobes and mar_out are registered Moore outputs.
// Backpressure: stalls in FETCH_WAIT until mem_rdy and in EXEC until exec_done; run gates new fetches.
// Ports: clk, rst (async, active-high), run, mem_rdy, exec_done, redir_valid, redir_addr[15:0]
//        -> pc[15:0], mar_out[15:0], ld_mar, mem_rd, ld_ir, fault, state[2:0].
// Optional: `FETCH_TIMEOUT_EN builds a FETCH_WAIT watchdog (rewinds pc, pulses fault, returns to IDLE).
import pc_fetch_sequencer_pkg::*;

module pc_fetch_sequencer #(
   parameter logic [15:0] RESET_PC       = RESET_PC_DEF,
   parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        mem_rdy,
   input  logic        exec_done,
   input  logic        redir_valid,
   input  logic [15:0] redir_addr,
   output logic [15:0] pc,
   output logic [15:0] mar_out,
   output logic        ld_mar,
   output logic        mem_rd,
   output logic        ld_ir,
   output logic        fault,
   output logic [2:0]  state
);

   state_t          state_q;
   state_t          state_nxt;
   pc_sel_t         pc_sel;
   logic [PC_W-1:0] pc_nxt;
   strobe_t         strb_q;
   logic            wait_expired;

   pc_next_mux u_pc_next_mux (
      .pc         (pc),
      .redir_addr (redir_addr),
      .sel        (pc_sel),
      .pc_nxt     (pc_nxt)
   );

   // Next state and PC source.
   always_comb begin
      state_nxt = ST_IDLE;
      pc_sel    = PC_HOLD;
      case (state_q)
         ST_IDLE: begin
            state_nxt = run ? ST_FETCH_ADDR : ST_IDLE;
         end
         ST_FETCH_ADDR: begin
            state_nxt = ST_FETCH_WAIT;
            pc_sel    = PC_INC;
         end
         ST_FETCH_WAIT: begin
            // mem_rdy wins over an expiring watchdog in the same cycle.
            if (mem_rdy) begin
               state_nxt = ST_LOAD_IR;
            end else if (wait_expired) begin
               state_nxt = ST_IDLE;
               pc_sel    = PC_DEC;
            end else begin
               state_nxt = ST_FETCH_WAIT;
            end
         end
         ST_LOAD_IR: begin
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (exec_done) begin
               state_nxt = run ? ST_FETCH_ADDR : ST_IDLE;
               if (redir_valid) begin
                  pc_sel = PC_REDIR;
               end
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc      <= RESET_PC;
         strb_q  <= '0;
         mar_out <= '0;
      end else begin
         state_q <= state_nxt;
         pc      <= pc_nxt;
         strb_q  <= decode_strobes(state_nxt);
         // pc_nxt is the value pc holds for the whole FETCH_ADDR cycle.
         mar_out <= (state_nxt == ST_FETCH_ADDR) ? pc_nxt : '0;
      end
   end

   assign ld_mar = strb_q.ld_mar;
   assign mem_rd = strb_q.mem_rd;
   assign ld_ir  = strb_q.ld_ir;
   assign state  = state_q;

`ifdef FETCH_TIMEOUT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  fault_q;

   // Counts completed WAIT cycles of the current fetch; restarts on every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_q != ST_FETCH_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // True during the TIMEOUT_CYCLES-th consecutive WAIT cycle.
   assign wait_expired = (state_q == ST_FETCH_WAIT) &&
                         (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state_q == ST_FETCH_WAIT) && !mem_rdy && wait_expired;
      end
   end

   assign fault = fault_q;
`else
   logic cfg_unused;
   assign cfg_unused   = (TIMEOUT_CYCLES > 0);
   assign wait_expired = 1'b0;
   assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

`ifdef FETCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [15:0] RST_PC  = 16'h3000;
   localparam int          TO_CYC  = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        mem_rdy = 1'b0;
   logic        exec_done = 1'b0;
   logic        redir_valid = 1'b0;
   logic [15:0] redir_addr = 16'h0;
   logic [15:0] pc;
   logic [15:0] mar_out;
   logic        ld_mar;
   logic        mem_rd;
   logic        ld_ir;
   logic        fault;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: phase number (0 idle, 1 addr, 2 wait, 3 load IR, 4 exec), pc value, fault pulse.
   int          m_phase;
   logic [15:0] m_pc;
   bit          m_fault;
   int          m_wait;

   pc_fetch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .mem_rdy     (mem_rdy),
      .exec_done   (exec_done),
      .redir_valid (redir_valid),
      .redir_addr  (redir_addr),
      .pc          (pc),
      .mar_out     (mar_out),
      .ld_mar      (ld_mar),
      .mem_rd      (mem_rd),
      .ld_ir       (ld_ir),
      .fault       (fault),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pc    = RST_PC;
      m_fault = 1'b0;
      m_wait  = 0;
   endtask

   // One clock edge of the instruction-cycle rules, using the inputs held at that edge.
   task automatic model_step();
      bit f;
      f = 1'b0;
      case (m_phase)
         0: if (run) m_phase = 1;
         1: begin
            m_pc    = m_pc + 16'd1;
            m_wait  = 0;
            m_phase = 2;
         end
         2: begin
            if (mem_rdy) m_phase = 3;
            else begin
               m_wait++;
               if (TO_EN && m_wait >= TO_CYC) begin
                  m_pc    = m_pc - 16'd1;
                  f       = 1'b1;
                  m_phase = 0;
               end
            end
         end
         3: m_phase = 4;
         4: if (exec_done) begin
            if (redir_valid) m_pc = redir_addr;
            m_phase = run ? 1 : 0;
         end
         default: m_phase = 0;
      endcase
      m_fault = f;
   endtask

   task automatic cmp_all();
      chk("state",   32'(state),   32'(m_phase));
      chk("pc",      32'(pc),      32'(m_pc));
      chk("ld_mar",  32'(ld_mar),  32'(m_phase == 1));
      chk("mar_out", 32'(mar_out), (m_phase == 1) ? 32'(m_pc) : 32'h0);
      chk("mem_rd",  32'(mem_rd),  32'(m_phase == 2));
      chk("ld_ir",   32'(ld_ir),   32'(m_phase == 3));
      chk("fault",   32'(fault),   32'(m_fault));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      cmp_all();
   endtask

   initial begin
      int          waits;
      bit          seen;
      logic [15:0] fetch_addr;

      // Power-on reset
      #1 rst = 1'b1;
      model_reset();
      #2 cmp_all();
      #9 rst = 1'b0;

      // Reset pulse in the middle of a fetch, checked before any clock edge
      run = 1'b1; mem_rdy = 1'b0;
      cyc();
      cyc();
      chk("mid_state_before", 32'(state), 32'd2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_pc",     32'(pc),     32'h3000);
      chk("arst_state",  32'(state),  32'd0);
      chk("arst_ld_mar", 32'(ld_mar), 32'd0);
      chk("arst_mem_rd", 32'(mem_rd), 32'd0);
      chk("arst_ld_ir",  32'(ld_ir),  32'd0);
      chk("arst_mar",    32'(mar_out), 32'd0);
      #2 rst = 1'b0;

      // Minimum-latency instruction, then the next fetch from 3001
      run = 1'b1; mem_rdy = 1'b1; exec_done = 1'b1;
      cyc();
      chk("t2_ld_mar1", 32'(ld_mar), 32'd1);
      chk("t2_mar1",    32'(mar_out), 32'h3000);
      cyc();
      chk("t2_pc",      32'(pc), 32'h3001);
      cyc();
      chk("t2_ld_ir",   32'(ld_ir), 32'd1);
      cyc();
      cyc();
      chk("t2_ld_mar5", 32'(ld_mar), 32'd1);
      chk("t2_mar5",    32'(mar_out), 32'h3001);

      // Redirect offered while execute is still busy is ignored until exec_done
      cyc();
      cyc();
      exec_done = 1'b0; redir_valid = 1'b1; redir_addr = 16'h4000;
      cyc();
      cyc();
      cyc();
      chk("t3_pc_hold", 32'(pc), 32'h3002);
      chk("t3_exec",    32'(state), 32'd4);
      exec_done = 1'b1;
      cyc();
      chk("t3_mar",     32'(mar_out), 32'h4000);

      // Redirect to FFFF and wrap on increment
      redir_addr = 16'hFFFF;
      cyc();
      cyc();
      cyc();
      cyc();
      chk("t4_mar",  32'(mar_out), 32'hFFFF);
      redir_valid = 1'b0;
      cyc();
      chk("t4_wrap", 32'(pc), 32'h0000);

      // run dropped during FETCH_WAIT: instruction completes, then IDLE
      run = 1'b0; mem_rdy = 1'b0;
      cyc();
      cyc();
      cyc();
      mem_rdy = 1'b1;
      cyc();
      chk("t5_ld_ir", 32'(ld_ir), 32'd1);
      cyc();
      cyc();
      chk("t5_idle", 32'(state), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_no_ld_mar", 32'(ld_mar), 32'd0);
      end

      // Memory never answers
      mem_rdy = 1'b0; run = 1'b1;
      waits = 0; seen = 1'b0; fetch_addr = 16'h0;
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (ld_mar) fetch_addr = mar_out;
         if (state == 3'd2) waits++;
         if (fault) begin
            seen = 1'b1;
            break;
         end
      end
      chk("t6_fault_seen", 32'(seen), 32'd1);
      chk("t6_wait_cycles", 32'(waits), 32'(TO_CYC));
      chk("t6_pc_rewind", 32'(pc), 32'(fetch_addr));
      chk("t6_idle", 32'(state), 32'd0);
      run = 1'b0;
      cyc();
      chk("t6_fault_1cyc", 32'(fault), 32'd0);
`else
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (fault) seen = 1'b1;
      end
      chk("t6_still_wait", 32'(state), 32'd2);
      chk("t6_mem_rd", 32'(mem_rd), 32'd1);
      chk("t6_no_fault", 32'(seen), 32'd0);
      mem_rdy = 1'b1;
      cyc();
`endif

      // Randomized traffic with occasional memory starvation windows
      for (int i = 0; i < 1500; i++) begin
         run         = ($urandom_range(0, 9) != 0);
         mem_rdy     = ($urandom_range(0, 3) == 0) && !((i % 300) < 20);
         exec_done   = ($urandom_range(0, 2) == 0);
         redir_valid = $urandom_range(0, 1) == 1;
         redir_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
